// File: rtl/my_logic_pipe.sv
// Pipelined two-operand bitwise logic unit (AND/OR/XOR/XNOR) with clock enable,
// valid/ready flow control and a running XOR accumulator over delivered results.
module my_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_PARITY,
  input  logic             ACC_EN,
  input  logic             ACC_CLR,
  output logic [WIDTH-1:0] ACC,
  output logic [CNT_W-1:0] COUNT
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       mode);
    case (mode)
      2'b00:   logic_op = a & b;
      2'b01:   logic_op = a | b;
      2'b10:   logic_op = a ^ b;
      default: logic_op = ~(a ^ b);
    endcase
  endfunction

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall, advance, in_fire, out_fire;

  // A stall anywhere freezes the whole pipe; bubbles are not squeezed out.
  always_comb begin
    stall      = v_q[STAGES-1] & ~OUT_READY;
    advance    = CE & ~stall;
    IN_READY   = advance & ~RESET;
    OUT_VALID  = v_q[STAGES-1] & CE & ~RESET;
    OUT_DATA   = d_q[STAGES-1];
    OUT_PARITY = ^d_q[STAGES-1];
    in_fire    = IN_VALID & IN_READY;
    out_fire   = OUT_VALID & OUT_READY;
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (advance) begin
      v_d[0] = in_fire;
      if (in_fire) d_d[0] = logic_op(IN_A, IN_B, MODE);
      for (int k = 1; k < STAGES; k++) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  // Clear has priority over folding a result that completes in the same cycle.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (CE) begin
      if (ACC_CLR) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (out_fire && ACC_EN) begin
        acc_d = acc_q ^ d_q[STAGES-1];
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      v_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign ACC   = acc_q;
  assign COUNT = cnt_q;

endmodule

// File: tb/tb_my_logic_pipe.sv
// Scoreboard bench for my_logic_pipe (WIDTH=8, STAGES=2, CNT_W=4).
module tb_my_logic_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic             CLK = 1'b0;
  logic             RESET, CE, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [WIDTH-1:0] IN_A, IN_B, OUT_DATA, ACC;
  logic [1:0]       MODE;
  logic             OUT_PARITY, ACC_EN, ACC_CLR;
  logic [CNT_W-1:0] COUNT;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] m_acc = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  my_logic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .MODE(MODE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_PARITY(OUT_PARITY), .ACC_EN(ACC_EN), .ACC_CLR(ACC_CLR),
    .ACC(ACC), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0]       m);
    case (m)
      2'b00:   ref_op = a & b;
      2'b01:   ref_op = a | b;
      2'b10:   ref_op = a ^ b;
      default: ref_op = ~(a ^ b);
    endcase
  endfunction

  // Monitor: compare accumulator state, then push accepted beats and pop delivered ones.
  always @(negedge CLK) begin
    logic [WIDTH-1:0] exp;
    logic             have;
    chk("acc", ACC, m_acc);
    chk("count", COUNT, m_cnt);
    have = 1'b0;
    exp  = '0;
    if (RESET) begin
      chk("reset_out_valid", OUT_VALID, 0);
      sb_q.delete();
      m_acc = '0;
      m_cnt = '0;
    end else begin
      if (IN_VALID && IN_READY) sb_q.push_back(ref_op(IN_A, IN_B, MODE));
      if (OUT_VALID && OUT_READY) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp  = sb_q.pop_front();
          have = 1'b1;
          chk("out_data", OUT_DATA, exp);
          chk("out_parity", OUT_PARITY, ^exp);
        end
      end
      if (CE) begin
        if (ACC_CLR) begin
          m_acc = '0;
          m_cnt = '0;
        end else if (have && ACC_EN) begin
          m_acc = m_acc ^ exp;
          m_cnt = m_cnt + 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] m);
    int t;
    t = 0;
    IN_A = a; IN_B = b; MODE = m; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY) begin
      t++;
      if (t > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
      @(negedge CLK);
    end
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] frz_d, frz_acc;
    logic [CNT_W-1:0] frz_cnt;
    int t0;
    RESET = 1'b1; CE = 1'b0; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; MODE = '0;
    OUT_READY = 1'b0; ACC_EN = 1'b0; ACC_CLR = 1'b0;

    // Reset and latency
    tick(2);
    @(negedge CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_out_parity", OUT_PARITY, 0);
    @(posedge CLK); #1;
    RESET = 1'b0; CE = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", IN_READY, 1);
    @(posedge CLK); #1;
    send(8'hF0, 8'h3C, 2'b10);
    @(negedge CLK);
    chk("lat_early", OUT_VALID, 0);
    @(negedge CLK);
    chk("lat_valid", OUT_VALID, 1);
    chk("lat_data", OUT_DATA, 8'hCC);
    chk("lat_parity", OUT_PARITY, 0);
    @(negedge CLK);
    chk("lat_one_cycle", OUT_VALID, 0);
    @(posedge CLK); #1;

    // All modes, streaming
    t0 = cyc;
    for (int i = 0; i < 4; i++) send(8'hA5, 8'h0F, 2'(i));
    chk("stream_cycles", cyc - t0, 4);
    @(negedge CLK);
    chk("stream_xor", OUT_DATA, 8'hAA);
    @(negedge CLK);
    chk("stream_xnor_valid", OUT_VALID, 1);
    chk("stream_xnor", OUT_DATA, 8'h55);
    @(posedge CLK); #1;
    tick(2);

    // Backpressure
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i * 17), 8'h0F, 2'(i % 4));
      end
      begin
        tick(3);
        OUT_READY = 1'b0;
        @(negedge CLK);
        frz_d = OUT_DATA;
        chk("bp_valid", OUT_VALID, 1);
        chk("bp_in_ready", IN_READY, 0);
        repeat (2) begin
          @(negedge CLK);
          chk("bp_in_ready", IN_READY, 0);
          chk("bp_frozen", OUT_DATA, frz_d);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
      end
    join
    tick(3);
    chk("bp_drained", sb_q.size(), 0);

    // Accumulator fold and clear-wins
    ACC_EN = 1'b1;
    send(8'h12, 8'h00, 2'b10);
    send(8'h34, 8'h00, 2'b10);
    send(8'h56, 8'h00, 2'b10);
    tick(3);
    chk("acc_fold", ACC, 8'h70);
    chk("acc_count", COUNT, 3);
    send(8'hFF, 8'h00, 2'b10);
    @(posedge CLK); #1;
    ACC_CLR = 1'b1;
    @(negedge CLK);
    chk("clr_fire_valid", OUT_VALID & OUT_READY, 1);
    chk("clr_fire_data", OUT_DATA, 8'hFF);
    @(posedge CLK); #1;
    ACC_CLR = 1'b0;
    @(negedge CLK);
    chk("clr_acc", ACC, 0);
    chk("clr_count", COUNT, 0);
    @(posedge CLK); #1;

    // Clock enable pause and counter wrap
    fork
      begin
        for (int i = 0; i < 17; i++)
          send(8'($urandom_range(255)), 8'($urandom_range(255)), 2'($urandom_range(3)));
      end
      begin
        tick(6);
        frz_d = OUT_DATA; frz_acc = ACC; frz_cnt = COUNT;
        CE = 1'b0;
        repeat (5) begin
          @(negedge CLK);
          chk("ce_in_ready", IN_READY, 0);
          chk("ce_out_valid", OUT_VALID, 0);
          chk("ce_data_hold", OUT_DATA, frz_d);
          chk("ce_acc_hold", ACC, frz_acc);
          chk("ce_cnt_hold", COUNT, frz_cnt);
        end
        @(posedge CLK); #1;
        CE = 1'b1;
      end
    join
    tick(3);
    chk("wrap_count", COUNT, 1);
    chk("wrap_drained", sb_q.size(), 0);

    // Reset with beats in flight
    send(8'h81, 8'h18, 2'b01);
    send(8'h0F, 8'hF0, 2'b00);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_valid", OUT_VALID, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("after_rst_valid", OUT_VALID, 0);
    chk("after_rst_acc", ACC, 0);
    chk("after_rst_count", COUNT, 0);
    chk("after_rst_in_ready", IN_READY, 1);
    @(posedge CLK); #1;
    tick(4);
    send(8'h3C, 8'h0F, 2'b10);
    tick(3);
    chk("final_drained", sb_q.size(), 0);
    chk("final_count", COUNT, 1);
    chk("final_acc", ACC, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
